// File: rtl/chunk_add_seq.sv
// Sequential N-bit adder/subtractor that reuses one CHUNK-bit adder slice,
// working from the least significant slice upward, one slice per cycle.
module chunk_add_seq #(
    parameter int unsigned CHUNK  = 16,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [CHUNK*CHUNKS-1:0]   a,
    input  logic [CHUNK*CHUNKS-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [CHUNK*CHUNKS-1:0]   sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero
);

    localparam int unsigned N    = CHUNK * CHUNKS;
    localparam int unsigned IdxW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      a_q, b_q, sum_q, sum_d;
    logic              carry_q, cout_q, ovf_q;
    logic [IdxW-1:0]   idx_q;
    logic              accept, last_slice;
    logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
    logic              c_out, msb_cin;

    assign last_slice = (idx_q == IdxW'(CHUNKS - 1));

    // The single shared slice adder and its operand selection.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (idx_q == IdxW'(k)) begin
                a_sl = a_q[k*CHUNK +: CHUNK];
                b_sl = b_q[k*CHUNK +: CHUNK];
            end
        end
        {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB, recovered from the MSB sum bit.
        msb_cin = s_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    end

    always_comb begin
        sum_d = sum_q;
        for (int k = 0; k < CHUNKS; k++) begin
            if (idx_q == IdxW'(k)) begin
                sum_d[k*CHUNK +: CHUNK] = s_sl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (busy) begin
            sum_q   <= sum_d;
            carry_q <= c_out;
            if (last_slice) begin
                cout_q <= c_out;
                ovf_q  <= msb_cin ^ c_out;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = (sum_q == '0);

endmodule
